sys_mem_responder: RTL and testbench
====================================

SYS_MEM_RESPONDER -- requirements
Module: sys_mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 3, meaning the number of wait cycles inserted before each response (legal range 0..15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of CDATA-wide storage words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port S_strobe, input, 1 bit: request valid, driven by the cache and held high until the response.
REQ-006 The block SHALL have port S_address, input, CADDR (32) bits: byte address.
REQ-007 The block SHALL have port S_rw, input, 1 bit: 1 = read, 0 = write.
REQ-008 The block SHALL have port S_data_in, input, CDATA (32) bits: write data from the cache.
REQ-009 The block SHALL have port S_data_out, output, CDATA (32) bits: read data to the cache.
REQ-010 The block SHALL have port S_ready, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port S_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, WAIT, RESP and DONE.
REQ-013 In IDLE with S_strobe=1 at an edge, the block SHALL latch S_address, S_rw and S_data_in, load the wait counter with WAIT_CYCLES, and enter WAIT.
REQ-014 In WAIT with S_strobe=1 and counter != 0, the block SHALL decrement the counter and remain in WAIT.
REQ-015 In WAIT with S_strobe=1 and counter == 0, the block SHALL perform the access using the latched values and enter RESP.
REQ-016 A write access SHALL store the latched data at the word index latched_address[DEPTH_LOG2+1:2].
REQ-017 A read access SHALL register the word at that index into S_data_out.
REQ-018 S_ready SHALL be 1 only in RESP and SHALL last exactly one cycle; S_data_out SHALL be valid in that cycle.
REQ-019 Response latency SHALL be WAIT_CYCLES+1 cycles: strobe sampled at edge k, S_ready high in the cycle following edge k+WAIT_CYCLES+1.
REQ-020 RESP SHALL go to IDLE if S_strobe=0, otherwise to DONE.
REQ-021 DONE SHALL hold until S_strobe=0 and then go to IDLE, so that a held strobe never re-triggers a request.
REQ-022 Changes to S_address, S_rw or S_data_in after the strobe is sampled SHALL have no effect on the access in progress.
REQ-023 S_strobe=0 during WAIT SHALL abort the access: return to IDLE, no write performed, no S_ready, S_data_out unchanged.
REQ-024 Address bits above DEPTH_LOG2+1 and bits [1:0] SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
REQ-025 S_data_out SHALL hold the last read data and SHALL be unchanged by writes.
REQ-026 With WAIT_CYCLES=0, the block SHALL pass through WAIT for exactly one cycle (latency 1).
REQ-027 A read issued immediately after a write to the same index SHALL return the newly written data.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set state to IDLE, counter to 0, S_ready=0, S_busy=0 and S_data_out=0, and SHALL abort any request in progress without performing its write.
REQ-029 Reset SHALL NOT clear storage contents.
REQ-030 A strobe that is high during the reset edge SHALL be ignored, and SHALL be sampled at the first edge with rst=0.

Structure
REQ-031 The CADDR/CDATA widths SHALL come from the existing shared cache definitions, and the state enum (IDLE, WAIT, RESP, DONE) SHALL be defined in a shared package sys_mem_pkg.
REQ-032 The storage array SHALL be one sub-module, sys_mem_array, with one synchronous read/write port; the FSM and counter SHALL live in the top-level block.

Verification
REQ-033 Scenario: after reset, write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 with WAIT_CYCLES=3 -> S_ready 4 cycles after each strobe, and the read returns 0xDEADBEEF.
REQ-034 Scenario: hold S_strobe high for 10 cycles after a read -> exactly one S_ready pulse, and S_busy stays high until the strobe drops.
REQ-035 Scenario: write 0x11111111 to 0x0, drop the strobe during WAIT cycle 2 of a write of 0x22222222 to 0x0, then read 0x0 -> returns 0x11111111, and no S_ready for the aborted access.
REQ-036 Scenario: with DEPTH_LOG2=10, write 0xA5A5A5A5 to 0x0000_1004, then read 0x0000_0004 -> returns 0xA5A5A5A5 (aliasing).
REQ-037 Scenario: assert rst during the WAIT of a write of 0x5 to 0x8 (0x8 previously 0x3), then read 0x8 -> outputs reset to 0, and the read returns 0x3.
REQ-038 Scenario: WAIT_CYCLES=0, back-to-back reads with one strobe-low cycle between them -> each S_ready comes 1 cycle after its strobe is sampled.

Source files
------------

// File: rtl/sys_mem_pkg.sv
// Shared cache widths, responder FSM state encoding and a wait-counter load helper.
package sys_mem_pkg;

    localparam int unsigned CADDR = 32;
    localparam int unsigned CDATA = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StDone
    } sys_mem_state_e;

    // Wait counts are 0..15, so the load value fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
        return CNT_W'(cycles);
    endfunction

endpackage

// File: rtl/sys_mem_responder_if.sv
// Cache-side request/response bus between a cache (master) and the memory responder (slave).
interface sys_mem_responder_if;
    import sys_mem_pkg::*;

    logic             S_strobe;
    logic [CADDR-1:0] S_address;
    logic             S_rw;
    logic [CDATA-1:0] S_data_in;
    logic [CDATA-1:0] S_data_out;
    logic             S_ready;
    logic             S_busy;

    modport master (
        output S_strobe, S_address, S_rw, S_data_in,
        input  S_data_out, S_ready, S_busy
    );

    modport slave (
        input  S_strobe, S_address, S_rw, S_data_in,
        output S_data_out, S_ready, S_busy
    );

endinterface

// File: rtl/sys_mem_array.sv
// Word storage with a single synchronous read/write port; the read register holds the
// last read word and is the only state cleared by reset.
module sys_mem_array
    import sys_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [CDATA-1:0]      wdata,
    output logic [CDATA-1:0]      rdata
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;

    logic [CDATA-1:0] mem [Words];
    logic [CDATA-1:0] rdata_q, rdata_d;

    // Read register only updates on a read access; writes leave it untouched.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    // Read data register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sys_mem_responder.sv
// Memory responder: latches a cache request, waits WAIT_CYCLES, performs one access and
// pulses S_ready for one cycle. A held strobe is parked in StDone until it drops.
module sys_mem_responder
    import sys_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned DEPTH_LOG2  = 10
) (
    input  logic                clk,
    input  logic                rst,
    sys_mem_responder_if.slave  bus
);

    sys_mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  rw_q, rw_d;
    logic [CDATA-1:0]      wdata_q, wdata_d;

    logic                  mem_en;
    logic                  mem_we;
    logic [CDATA-1:0]      mem_rdata;

    // Next-state, request latching and access strobe generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.S_strobe) begin
                    idx_d   = bus.S_address[DEPTH_LOG2+1:2];
                    rw_d    = bus.S_rw;
                    wdata_d = bus.S_data_in;
                    cnt_d   = wait_load(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!bus.S_strobe) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_en  = 1'b1;
                    mem_we  = !rw_q;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = bus.S_strobe ? StDone : StIdle;
            end
            StDone: begin
                if (!bus.S_strobe) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An access due on a reset edge is dropped, so an aborted write never lands.
        if (rst) begin
            mem_en = 1'b0;
        end
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
        end
    end

    sys_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .en   (mem_en),
        .we   (mem_we),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    // Status outputs decoded from the registered state.
    always_comb begin
        bus.S_ready    = (state_q == StResp);
        bus.S_busy     = (state_q != StIdle);
        bus.S_data_out = mem_rdata;
    end

endmodule

// File: tb/tb_sys_mem_responder.sv
// Self-checking bench: dut_a (WAIT_CYCLES=3) runs a table of transactions and the
// multi-cycle corner cases; dut_b (WAIT_CYCLES=0) runs back-to-back accesses.
module tb_sys_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sys_mem_responder_if ia ();
    sys_mem_responder_if ib ();

    sys_mem_responder #(
        .WAIT_CYCLES(3),
        .DEPTH_LOG2 (10)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ia.slave)
    );

    sys_mem_responder #(
        .WAIT_CYCLES(0),
        .DEPTH_LOG2 (10)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ib.slave)
    );

    int checks = 0;
    int errors = 0;

    // Selects which DUT the helper tasks drive and observe.
    logic        cur = 1'b0;
    logic        rdy;
    logic        bsy;
    logic [31:0] dout;

    always_comb begin
        rdy  = cur ? ib.S_ready    : ia.S_ready;
        bsy  = cur ? ib.S_busy     : ia.S_busy;
        dout = cur ? ib.S_data_out : ia.S_data_out;
    end

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic stb, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data);
        if (cur) begin
            ib.S_strobe = stb; ib.S_rw = rw; ib.S_address = addr; ib.S_data_in = data;
        end else begin
            ia.S_strobe = stb; ia.S_rw = rw; ia.S_address = addr; ia.S_data_in = data;
        end
    endtask

    task automatic set_stb(input logic stb);
        if (cur) ib.S_strobe = stb;
        else     ia.S_strobe = stb;
    endtask

    // Raise the strobe for one sampling edge, then scramble the request fields.
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        set_req(1'b1, rw, addr, data);
        step();
        set_req(1'b1, ~rw, ~addr, ~data);
    endtask

    // Called just after the sampling edge: checks latency and data, then drops the strobe.
    task automatic finish_txn(input int exp_lat, input logic [31:0] exp_dout,
                              input string name);
        int n = 0;
        chk({name, " busy_after_strobe"}, 32'(bsy), 32'd1);
        chk({name, " ready_early"}, 32'(rdy), 32'd0);
        while (!rdy && n < 20) begin
            step();
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
        chk({name, " data_out"}, dout, exp_dout);
        set_stb(1'b0);
        step();
        chk({name, " ready_one_cycle"}, 32'(rdy), 32'd0);
        chk({name, " idle_busy"}, 32'(bsy), 32'd0);
    endtask

    initial begin
        int pulses;
        int busy_low;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_1004, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h0000_0004, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h1111_1111, 32'hA5A5_A5A5};
        vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h1234_5678, 32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 32'h3FFF_FFFE, 32'h0000_0000, 32'h1234_5678};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111};
        vecs[8] = '{1'b0, 32'h0000_0008, 32'h0000_0003, 32'h1111_1111};
        vecs[9] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0000_0003};

        ia.S_strobe = 1'b0; ia.S_rw = 1'b0; ia.S_address = '0; ia.S_data_in = '0;
        ib.S_strobe = 1'b0; ib.S_rw = 1'b0; ib.S_address = '0; ib.S_data_in = '0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset a busy", 32'(ia.S_busy), 32'd0);
        chk("reset a ready", 32'(ia.S_ready), 32'd0);
        chk("reset a data_out", ia.S_data_out, 32'd0);
        chk("reset b busy", 32'(ib.S_busy), 32'd0);
        chk("reset b data_out", ib.S_data_out, 32'd0);

        // Table-driven transactions on the WAIT_CYCLES=3 instance.
        cur = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            finish_txn(4, vecs[i].dout, $sformatf("vec%0d", i));
        end

        // Strobe held for 10 cycles after the response: one pulse, busy until the drop.
        issue(1'b1, 32'h0000_0010, 32'h0);
        pulses = 0;
        while (!rdy && pulses < 20) begin
            step();
            pulses++;
        end
        chk("held latency", 32'(pulses), 32'd4);
        chk("held data_out", dout, 32'hDEAD_BEEF);
        pulses   = 0;
        busy_low = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy) pulses++;
            if (!bsy) busy_low++;
        end
        chk("held extra_ready", 32'(pulses), 32'd0);
        chk("held busy_low", 32'(busy_low), 32'd0);
        set_stb(1'b0);
        step();
        chk("held release busy", 32'(bsy), 32'd0);

        // Abort a write in its second wait cycle; storage and data_out must not change.
        issue(1'b0, 32'h0000_0000, 32'h2222_2222);
        step();
        set_stb(1'b0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rdy) pulses++;
        end
        chk("abort ready", 32'(pulses), 32'd0);
        chk("abort busy", 32'(bsy), 32'd0);
        chk("abort data_out", dout, 32'hDEAD_BEEF);
        issue(1'b1, 32'h0000_0000, 32'h0);
        finish_txn(4, 32'h1111_1111, "abort readback");

        // Reset during the wait of a write; a strobe held across reset is taken afterwards.
        issue(1'b0, 32'h0000_0008, 32'h0000_0005);
        step();
        rst = 1'b1;
        set_req(1'b1, 1'b1, 32'h0000_0008, 32'h0);
        step();
        chk("rst busy", 32'(bsy), 32'd0);
        chk("rst ready", 32'(rdy), 32'd0);
        chk("rst data_out", dout, 32'd0);
        rst = 1'b0;
        step();
        finish_txn(4, 32'h0000_0003, "post_rst read");
        issue(1'b1, 32'h0000_0010, 32'h0);
        finish_txn(4, 32'hDEAD_BEEF, "storage kept");

        // WAIT_CYCLES=0 instance, one strobe-low cycle between requests.
        cur = 1'b1;
        issue(1'b0, 32'h0000_0020, 32'hCAFE_F00D);
        finish_txn(1, 32'h0, "b wr0");
        issue(1'b0, 32'h0000_0024, 32'h0BAD_F00D);
        finish_txn(1, 32'h0, "b wr1");
        issue(1'b1, 32'h0000_0020, 32'h0);
        finish_txn(1, 32'hCAFE_F00D, "b rd0");
        issue(1'b1, 32'h0000_0024, 32'h0);
        finish_txn(1, 32'h0BAD_F00D, "b rd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
